// File: rtl/branch_predictor_if.sv
// Predictor bus: F-stage lookup, D-stage update/training and invalidation.
// The master drives lookups and resolved branches; the slave is the predictor.
interface branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int HIST_W = 4
) ();
    logic              lookup_en;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [HIST_W-1:0] pred_hist;
    logic              update_en;
    logic [ADDR_W-1:0] update_pc;
    logic              update_taken;
    logic [ADDR_W-1:0] update_target;
    logic [HIST_W-1:0] update_hist;
    logic              inv_all;

    modport master (
        output lookup_en, lookup_pc,
        input  pred_hit, pred_taken, pred_target, pred_hist,
        output update_en, update_pc, update_taken, update_target, update_hist,
        output inv_all
    );

    modport slave (
        input  lookup_en, lookup_pc,
        output pred_hit, pred_taken, pred_target, pred_hist,
        input  update_en, update_pc, update_taken, update_target, update_hist,
        input  inv_all
    );
endinterface

// File: rtl/branch_predictor.sv
// Branch target buffer plus 2-bit saturating direction counters.
// Lookup is combinational (read-before-write against a same-cycle update);
// training and invalidation take effect on the next rising edge.
// Optional gshare counter indexing: define BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int HIST_W  = 4
) (
    input  logic clk,
    input  logic reset,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [IDX_W-1:0]   w_lk_cidx;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic [IDX_W-1:0]   w_up_cidx;
    logic               w_up_hit;
    logic               w_lk_hit;
    logic               w_lk_taken;
    logic [ADDR_W-1:0]  w_lk_target;
    logic [HIST_W-1:0]  w_hist;
    logic               w_unused_bits;

    assign w_lk_idx = bus.lookup_pc[IDX_W+1:2];
    assign w_lk_tag = bus.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_up_idx = bus.update_pc[IDX_W+1:2];
    assign w_up_tag = bus.update_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Only the index/tag fields of the PCs matter; the rest is ignored by design.
    assign w_unused_bits = ^{bus.lookup_pc, bus.update_pc, bus.update_hist};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [HIST_W-1:0] r_ghr;

    assign w_lk_cidx = w_lk_idx ^ IDX_W'(r_ghr);
    assign w_up_cidx = w_up_idx ^ IDX_W'(bus.update_hist);
    assign w_hist    = r_ghr;

    // Global history: shift in each resolved direction; cleared by inv_all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (bus.inv_all) begin
            r_ghr <= '0;
        end else if (bus.update_en) begin
            r_ghr <= {r_ghr[HIST_W-2:0], bus.update_taken};
        end
    end
`else
    assign w_lk_cidx = w_lk_idx;
    assign w_up_cidx = w_up_idx;
    assign w_hist    = '0;
`endif

    // Valid bits and counters: cleared by reset/inv_all, trained by updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_ctr   <= '{default: 2'b01};
        end else if (bus.inv_all) begin
            r_valid <= '0;
            r_ctr   <= '{default: 2'b01};
        end else if (bus.update_en) begin
            if (w_up_hit) begin
                if (bus.update_taken && (r_ctr[w_up_cidx] != 2'b11)) begin
                    r_ctr[w_up_cidx] <= r_ctr[w_up_cidx] + 2'b01;
                end else if (!bus.update_taken && (r_ctr[w_up_cidx] != 2'b00)) begin
                    r_ctr[w_up_cidx] <= r_ctr[w_up_cidx] - 2'b01;
                end
            end else if (bus.update_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_cidx]  <= 2'b10;
            end
        end
    end

    // Tag/target payload: written on every taken update (allocation or retarget).
    always_ff @(posedge clk) begin
        if (bus.update_en && bus.update_taken && !bus.inv_all) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bus.update_target;
        end
    end

    // Combinational prediction from the current (pre-update) table state.
    always_comb begin
        w_lk_hit    = bus.lookup_en && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        w_lk_taken  = w_lk_hit && r_ctr[w_lk_cidx][1];
        w_lk_target = bus.lookup_pc + ADDR_W'(4);
        if (w_lk_taken) begin
            w_lk_target = r_target[w_lk_idx];
        end
    end

    assign bus.pred_hit    = w_lk_hit;
    assign bus.pred_taken  = w_lk_taken;
    assign bus.pred_target = w_lk_target;
    assign bus.pred_hist   = w_hist;
endmodule
